// File: rtl/kvs_search_insert_accum.sv
// Generic show-ahead FIFO for the input, check and rest record queues.
// Latency: a push is visible at pop_dat one cycle later; pop_dat always shows the head.
// Backpressure: a push while full or a pop while empty is ignored; callers gate on count.
module kvs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   xrst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign pop_dat = mem[rd_ptr];

  // storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // read/write pointers and occupancy
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// Search-then-insert front end: SEARCH all buffered records, UPDATE the misses, emit accumulator writes.
// Latency: command registered one cycle after issue; accum write exactly one cycle after its ack.
// Backpressure: issue stalls on cam_ready, MAX_OUT in flight or rest space; input overflow is dropped and counted.
module kvs_search_insert_accum #(
  parameter int KEY_W    = 128,
  parameter int VAL_W    = 32,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 16,
  parameter int MAX_OUT  = 8,
  parameter int INC_MODE = 0
) (
  input  logic                   clk,
  input  logic                   xrst,
  input  logic                   kick,
  output logic                   busy,
  output logic                   done,
  input  logic [KEY_W+VAL_W-1:0] din,
  input  logic                   we,
  output logic                   full,
  input  logic                   cam_ready,
  output logic                   cam_cmd_valid,
  output logic                   cam_cmd_search,
  output logic                   cam_cmd_update,
  output logic [KEY_W-1:0]       cam_key,
  output logic [VAL_W-1:0]       cam_value,
  input  logic                   cam_ack,
  input  logic                   cam_hit,
  input  logic                   cam_ent_full,
  input  logic [ADDR_W-1:0]      cam_ent_addr,
  output logic [ADDR_W-1:0]      accum_addr,
  output logic [2*VAL_W-1:0]     accum_din,
  output logic                   accum_we,
  output logic [31:0]            stat_hits,
  output logic [31:0]            stat_inserts,
  output logic [31:0]            stat_drops
);
  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic [KEY_W-1:0] key;
  } rec_t;

  typedef enum logic [1:0] {IDLE, SEARCH, INSERT, FIN} state_t;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW-1:0] FULL_MARK = CW'(DEPTH - 4);
  localparam logic [CW:0]   OCC_LIMIT = (CW+1)'(DEPTH);

  state_t           state;
  state_t           state_nxt;
  rec_t             in_dat;
  rec_t             chk_dat;
  rec_t             rest_dat;
  rec_t             issue_rec;
  logic [CW-1:0]    in_cnt;
  logic [CW-1:0]    rest_cnt;
  logic [CW-1:0]    outst;
  logic [CW:0]      occ;
  logic             in_push;
  logic             in_drop;
  logic             can_issue;
  logic             issue_search;
  logic             issue_insert;
  logic             issue;
  logic             ack_ok;
  logic             hit_wr;
  logic             miss;
  logic             ins_wr;
  logic             ins_drop;
  logic             acc_wr;
  logic             kick_go;
  logic [1:0]       drop_inc;
  logic [VAL_W-1:0] inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Overflowing writes are discarded rather than stalling the producer.
  assign in_push = we && (in_cnt != DEPTH_C);
  assign in_drop = we && (in_cnt == DEPTH_C);
  assign full    = (in_cnt >= FULL_MARK);

  // Misses still in flight will land in rest, so reserve room for them before searching more.
  assign occ          = {1'b0, rest_cnt} + {1'b0, outst};
  assign can_issue    = (outst < MAX_OUT_C) && cam_ready;
  assign issue_search = (state == SEARCH) && (in_cnt != '0) && can_issue && (occ < OCC_LIMIT);
  assign issue_insert = (state == INSERT) && (rest_cnt != '0) && can_issue;
  assign issue        = issue_search || issue_insert;
  assign issue_rec    = issue_search ? in_dat : rest_dat;

  // Responses return in issue order, so the check FIFO head always matches the ack.
  assign ack_ok   = cam_ack && (outst != '0);
  assign hit_wr   = ack_ok && (state == SEARCH) && cam_hit;
  assign miss     = ack_ok && (state == SEARCH) && !cam_hit;
  assign ins_wr   = ack_ok && (state == INSERT) && !cam_ent_full;
  assign ins_drop = ack_ok && (state == INSERT) && cam_ent_full;
  assign acc_wr   = hit_wr || ins_wr;
  assign inc      = (INC_MODE != 0) ? chk_dat.value : VAL_W'(1);
  assign kick_go  = (state == IDLE) && kick;
  assign drop_inc = {1'b0, in_drop} + {1'b0, ins_drop};

  kvs_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .xrst(xrst),
    .push(in_push), .push_dat(din),
    .pop(issue_search), .pop_dat(in_dat),
    .count(in_cnt)
  );

  // The check FIFO holds exactly the issued-but-unacked records, so its occupancy
  // is the outstanding count: +1 on issue, -1 on ack, unchanged when both coincide.
  kvs_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_chk_fifo (
    .clk(clk), .xrst(xrst),
    .push(issue), .push_dat(issue_rec),
    .pop(ack_ok), .pop_dat(chk_dat),
    .count(outst)
  );

  kvs_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_rest_fifo (
    .clk(clk), .xrst(xrst),
    .push(miss), .push_dat(chk_dat),
    .pop(issue_insert), .pop_dat(rest_dat),
    .count(rest_cnt)
  );

  // batch state register
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // batch sequencing: search everything queued, then insert the misses
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (kick) state_nxt = SEARCH;
      SEARCH:  if ((in_cnt == '0) && (outst == '0)) state_nxt = INSERT;
      INSERT:  if ((rest_cnt == '0) && (outst == '0)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    busy = (state == SEARCH) || (state == INSERT);
    done = (state == FIN);
  end

  // registered kernel command
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      cam_cmd_valid  <= 1'b0;
      cam_cmd_search <= 1'b0;
      cam_cmd_update <= 1'b0;
      cam_key        <= '0;
      cam_value      <= '0;
    end else begin
      cam_cmd_valid  <= issue;
      cam_cmd_search <= issue_search;
      cam_cmd_update <= issue_insert;
      if (issue) begin
        cam_key   <= issue_rec.key;
        cam_value <= issue_rec.value;
      end
    end
  end

  // accumulator write one cycle after a hit or successful insert ack
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      accum_we   <= 1'b0;
      accum_addr <= '0;
      accum_din  <= '0;
    end else begin
      accum_we <= acc_wr;
      if (acc_wr) begin
        accum_addr <= cam_ent_addr;
        accum_din  <= {chk_dat.value, inc};
      end
    end
  end

  // saturating per-batch statistics, cleared when a batch starts
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      stat_hits    <= '0;
      stat_inserts <= '0;
      stat_drops   <= '0;
    end else if (kick_go) begin
      stat_hits    <= '0;
      stat_inserts <= '0;
      stat_drops   <= sat_add(32'd0, drop_inc);
    end else begin
      stat_hits    <= sat_add(stat_hits, {1'b0, hit_wr});
      stat_inserts <= sat_add(stat_inserts, {1'b0, ins_wr});
      stat_drops   <= sat_add(stat_drops, drop_inc);
    end
  end
endmodule
